// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract controller. A single 1-bit adder cell (two cascaded
// half-adders plus a carry flop) is stepped once per clock, LSB first, for
// WIDTH cycles. Operands are captured on an accepted start. The result, the
// carry out of the MSB and the signed overflow are then presented through a
// start/busy/done handshake.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   start      operation request, sampled only while idle
//   sub        0 = A+B, 1 = A-B; captured together with the operands
//   abort      synchronous cancel of an operation in progress
//   op_a/op_b  WIDTH-bit operands, captured on the accepting edge
//   busy       high while the serial cell is running
//   done       one-cycle pulse when result/carry_out/overflow are fresh
//   result     sum/difference; holds until the next completion
//   carry_out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   two's-complement overflow of the last completed operation
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             abort,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Half-adder cell: returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   state_t           state_q,     state_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic             carry_q,     carry_d;
   logic [WIDTH-1:0] a_sr_q,      a_sr_d;
   logic [WIDTH-1:0] b_sr_q,      b_sr_d;
   logic [WIDTH-1:0] res_sr_q,    res_sr_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q,  overflow_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;

   logic [1:0]       ha1_s;
   logic [1:0]       ha2_s;
   logic             sum_bit_s;
   logic             carry_new_s;

   // Serial adder cell: half-adder(a0,b0) feeding half-adder(s1,carry flop).
   always_comb begin
      ha1_s       = half_add(a_sr_q[0], b_sr_q[0]);
      ha2_s       = half_add(ha1_s[0], carry_q);
      sum_bit_s   = ha2_s[0];
      carry_new_s = ha1_s[1] | ha2_s[1];
   end

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      a_sr_d      = a_sr_q;
      b_sr_d      = b_sr_q;
      res_sr_d    = res_sr_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d   = op_a;
               // Subtract is A + ~B + 1: invert B here, the +1 is the carry-in.
               b_sr_d   = sub ? ~op_b : op_b;
               carry_d  = sub;
               cnt_d    = CNT_ZERO;
               res_sr_d = {WIDTH{1'b0}};
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end

         ST_RUN: begin
            // Abort wins even on the final bit; published outputs stay put.
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
               b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
               res_sr_d = {sum_bit_s, res_sr_q[WIDTH-1:1]};
               carry_d  = carry_new_s;
               cnt_d    = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  result_d    = {sum_bit_s, res_sr_q[WIDTH-1:1]};
                  carry_out_d = carry_new_s;
                  // carry_q is the carry into the MSB on this final step.
                  overflow_d  = carry_q ^ carry_new_s;
                  state_d     = ST_DONE;
               end else begin
                  state_d     = ST_RUN;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake flags are registered copies of the next state decode.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         carry_q     <= 1'b0;
         a_sr_q      <= {WIDTH{1'b0}};
         b_sr_q      <= {WIDTH{1'b0}};
         res_sr_q    <= {WIDTH{1'b0}};
         result_q    <= {WIDTH{1'b0}};
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         res_sr_q    <= res_sr_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Scoreboard bench for serial_add_ctrl (WIDTH=8). Each accepted operation pushes
// {carry_out, overflow, result} computed by plain integer arithmetic onto a
// queue. An independent monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic         abort;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int checks   = 0;
   int failures = 0;

   logic [W+1:0] exp_q[$];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .abort     (abort),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   // Reference: {carry_out, overflow, result} from integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
      int ua, ub, sa, sb, r, sr;
      logic c, v;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (s) begin
         r  = ua - ub;
         c  = (ua >= ub);
         sr = sa - sb;
      end else begin
         r  = ua + ub;
         c  = (r > 255);
         sr = sa + sb;
      end
      v = (sr > 127) || (sr < -128);
      return {c, v, r[W-1:0]};
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done expected=no_done result=0x%0h", result);
         end else begin
            check("done_result", {22'd0, carry_out, overflow, result}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit push, input bit ab);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      abort = ab;
      if (push) exp_q.push_back(model(a, b, s));
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      op_a  = 8'($urandom);
      op_b  = 8'($urandom);
      sub   = 1'($urandom);
   endtask

   // Follows one operation from the cycle after acceptance; optionally
   // injects a stray start or an abort at a given RUN cycle index.
   task automatic wait_done(input int inj_start, input int inj_abort, input bit exp_done);
      int nb;
      bit seen;
      nb   = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nb++;
         else if (i > 0) break;
         if (i == inj_start) begin
            start = 1'b1;
            op_a  = 8'hFF;
         end else begin
            start = 1'b0;
         end
         abort = (i == inj_abort);
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      if (exp_done) begin
         check("done_seen", {31'd0, seen}, 32'd1);
         check("busy_width", nb, 32'd8);
         @(negedge clk);
         check("idle_after_done", {30'd0, busy, done}, 32'd0);
      end else begin
         check("no_done", {31'd0, seen}, 32'd0);
         check("abort_busy_width", nb, inj_abort + 1);
         @(negedge clk);
         check("no_late_done", {30'd0, busy, done}, 32'd0);
      end
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      issue(a, b, s, 1'b1, 1'b0);
      wait_done(-1, -1, 1'b1);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rs;

      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      abort = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {20'd0, busy, done, carry_out, overflow, result}, 32'd0);
      rst_n = 1'b1;

      // Directed cases.
      op(8'h0F, 8'h01, 1'b0);
      op(8'hFF, 8'h01, 1'b0);
      op(8'h7F, 8'h01, 1'b0);
      op(8'h05, 8'h07, 1'b1);
      op(8'h80, 8'h01, 1'b1);

      // Stray start during RUN is ignored.
      issue(8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
      wait_done(2, -1, 1'b1);
      check("stray_start_result", {24'd0, result}, 32'h33);

      // Abort mid-run keeps the previous result.
      op(8'h01, 8'h01, 1'b0);
      issue(8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
      wait_done(-1, 3, 1'b0);
      check("abort_hold", {22'd0, carry_out, overflow, result}, 32'h002);
      op(8'h10, 8'h10, 1'b0);

      // Abort on the final bit beats completion.
      issue(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
      wait_done(-1, 7, 1'b0);
      check("final_abort_hold", {24'd0, result}, 32'h20);

      // start and abort together in IDLE: start wins.
      issue(8'hC0, 8'h50, 1'b1, 1'b1, 1'b1);
      wait_done(-1, -1, 1'b1);

      // Async reset mid-run.
      issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_midrun", {20'd0, busy, done, carry_out, overflow, result}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op(8'hAA, 8'h55, 1'b0);

      // Randomized operations.
      for (int n = 0; n < 40; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         op(ra, rb, rs);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
